// File: rtl/midi_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : midi_tx_if
//  Description : Event handshake bundle between voice/sequencer logic and the
//                MIDI serializer. The master presents one MIDI event and holds
//                midi_event_valid until the slave returns a one-cycle
//                midi_event_ack.
//  Signals     : midi_command      [7:0]  MIDI status byte
//                midi_parameter_1  [6:0]  first data byte
//                midi_parameter_2  [6:0]  second data byte
//                midi_event_valid         event on the bus is valid
//                midi_event_ack           event consumed (sent or dropped)
//  Revision    : 1.0 - initial release
// ============================================================================
interface midi_tx_if;
    logic [7:0] midi_command;
    logic [6:0] midi_parameter_1;
    logic [6:0] midi_parameter_2;
    logic       midi_event_valid;
    logic       midi_event_ack;

    modport master (
        output midi_command,
        output midi_parameter_1,
        output midi_parameter_2,
        output midi_event_valid,
        input  midi_event_ack
    );

    modport slave (
        input  midi_command,
        input  midi_parameter_1,
        input  midi_parameter_2,
        input  midi_event_valid,
        output midi_event_ack
    );
endinterface
`default_nettype wire

// File: rtl/midi_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : midi_tx
//  Description : MIDI event serializer. Takes one event per handshake,
//                expands it into a 2- or 3-byte MIDI message and sends it on
//                an 8N1 serial line (start bit, 8 data bits LSB first, stop
//                bit), every bit lasting CLOCK_FREQUENCY/BAUD_RATE clocks.
//                System-common / realtime commands (0xF_) and bytes with the
//                MSB clear are acknowledged but dropped.
//  Ports       : clk        system clock, rising edge
//                resetn     asynchronous active-low reset
//                evt_if     event handshake (midi_tx_if.slave)
//                serial_tx  MIDI OUT line, idle high
//                busy       transmitter occupied, no event accepted
//  Options     : MIDI_TX_RUNNING_STATUS_EN - when defined, a channel command
//                equal to the last one sent omits its status byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module midi_tx #(
    parameter int CLOCK_FREQUENCY = 16000000,
    parameter int BAUD_RATE       = 31250
) (
    input  wire logic  clk,
    input  wire logic  resetn,
    midi_tx_if.slave   evt_if,
    output logic       serial_tx,
    output logic       busy
);

    localparam int c_div   = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int c_cnt_w = (c_div > 1) ? $clog2(c_div) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(c_div - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_baud;
    logic [c_cnt_w-1:0] w_baud_nxt;
    logic [2:0]         r_bit;
    logic [2:0]         w_bit_nxt;
    logic [1:0]         r_byte;      // index of the byte on the line
    logic [1:0]         w_byte_nxt;
    logic [1:0]         r_last;      // index of the final byte of the message
    logic [7:0]         r_msg0;
    logic [7:0]         r_msg1;
    logic [7:0]         r_msg2;
    logic               r_ack;

    logic               w_accept;
    logic               w_drop;
    logic               w_two;
    logic               w_skip;
    logic               w_wrap;
    logic [7:0]         w_cur;

    // Classification works on the live inputs in the acceptance cycle, the
    // same cycle in which they are captured.
    assign w_accept = (r_state == S_IDLE) && evt_if.midi_event_valid;
    assign w_drop   = !evt_if.midi_command[7] || (evt_if.midi_command[7:4] == 4'hF);
    assign w_two    = (evt_if.midi_command[7:4] == 4'hC) ||
                      (evt_if.midi_command[7:4] == 4'hD);
    assign w_wrap   = (r_baud == c_cnt_max);

`ifdef MIDI_TX_RUNNING_STATUS_EN
    logic [7:0] r_last_status;

    // last_status only ever holds a channel command or 0x00, so an equal
    // compare is enough to recognise a repeat of a sendable command.
    assign w_skip = (evt_if.midi_command == r_last_status);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_status <= 8'h00;
        end else if (w_accept) begin
            r_last_status <= w_drop ? 8'h00 : evt_if.midi_command;
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_byte  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_byte  <= w_byte_nxt;
        end
    end

    // Event capture and acknowledge. Dropped events are acknowledged too.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ack  <= 1'b0;
            r_last <= 2'd2;
            r_msg0 <= 8'h00;
            r_msg1 <= 8'h00;
            r_msg2 <= 8'h00;
        end else begin
            r_ack <= w_accept;
            if (w_accept) begin
                r_last <= w_two ? 2'd1 : 2'd2;
                r_msg0 <= evt_if.midi_command;
                r_msg1 <= {1'b0, evt_if.midi_parameter_1};
                r_msg2 <= {1'b0, evt_if.midi_parameter_2};
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;

        if (r_state != S_IDLE) begin
            w_baud_nxt = w_wrap ? '0 : r_baud + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_drop) begin
                    w_state_nxt = S_START;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    // Running status starts the message at the first data byte.
                    w_byte_nxt  = w_skip ? 2'd1 : 2'd0;
                end
            end
            S_START: begin
                if (w_wrap) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_wrap) begin
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_bit_nxt   = 3'd0;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_wrap) begin
                    if (r_byte == r_last) begin
                        w_state_nxt = S_IDLE;
                        w_byte_nxt  = 2'd0;
                    end else begin
                        // Next byte follows straight after the stop bit.
                        w_state_nxt = S_START;
                        w_byte_nxt  = r_byte + 2'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        case (r_byte)
            2'd0:    w_cur = r_msg0;
            2'd1:    w_cur = r_msg1;
            default: w_cur = r_msg2;
        endcase
    end

    // Decoded straight from the state register so that an asserted reset
    // returns the line high without waiting for a clock.
    always_comb begin
        serial_tx = 1'b1;
        case (r_state)
            S_START: serial_tx = 1'b0;
            S_DATA:  serial_tx = w_cur[r_bit];
            default: serial_tx = 1'b1;
        endcase
    end

    assign busy                  = (r_state != S_IDLE);
    assign evt_if.midi_event_ack = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_midi_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_midi_tx
//  Description : Scoreboard bench for midi_tx. The driver pushes the expected
//                line bytes and busy lengths of every event; independent
//                monitors decode the serial line and time the busy pulse and
//                compare against those queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_midi_tx;

    localparam int CLK_HZ = 500000;
    localparam int BAUD   = 31250;
    localparam int DIV    = CLK_HZ / BAUD;   // 16 clocks per bit
    localparam int LIMIT  = 40 * DIV + 100;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic serial_tx;
    logic busy;

    midi_tx_if bus ();

    midi_tx #(
        .CLOCK_FREQUENCY (CLK_HZ),
        .BAUD_RATE       (BAUD)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .evt_if    (bus),
        .serial_tx (serial_tx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_bytes[$];
    int         exp_busy[$];
    logic [7:0] model_status = 8'h00;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: expected bytes and busy length of one event.
    function automatic int push_expect(input logic [7:0] cmd, input logic [6:0] p1,
                                       input logic [6:0] p2);
        int  nb;
        bit  two;
        bit  skip;
        nb = 0;
        if (!cmd[7] || cmd[7:4] == 4'hF) begin
            model_status = 8'h00;
            return 0;
        end
        two  = (cmd[7:4] == 4'hC) || (cmd[7:4] == 4'hD);
`ifdef MIDI_TX_RUNNING_STATUS_EN
        skip = (cmd == model_status);
`else
        skip = 1'b0;
`endif
        model_status = cmd;
        if (!skip) begin exp_bytes.push_back(cmd); nb++; end
        exp_bytes.push_back({1'b0, p1}); nb++;
        if (!two) begin exp_bytes.push_back({1'b0, p2}); nb++; end
        exp_busy.push_back(10 * nb * DIV);
        return nb;
    endfunction

    // ------------------------------------------------------------------
    // Serial line decoder: samples mid-bit, compares each byte on the stop bit
    // ------------------------------------------------------------------
    initial begin : rx_monitor
        bit         rx_active;
        int         rx_cnt;
        logic [7:0] rx_sh;
        rx_active = 1'b0;
        rx_cnt    = 0;
        rx_sh     = 8'h00;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                rx_active = 1'b0;
            end else if (!rx_active) begin
                if (serial_tx == 1'b0) begin
                    rx_active = 1'b1;
                    rx_cnt    = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt == DIV / 2) begin
                    check("start_bit", int'(serial_tx), 0);
                end else if (rx_cnt % DIV == DIV / 2 && rx_cnt / DIV >= 1 && rx_cnt / DIV <= 8) begin
                    rx_sh[rx_cnt / DIV - 1] = serial_tx;
                end else if (rx_cnt == 9 * DIV + DIV / 2) begin
                    check("stop_bit", int'(serial_tx), 1);
                    if (exp_bytes.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_byte: got 0x%0h expected no byte (cycle %0d)", rx_sh, cyc);
                    end else begin
                        check("rx_byte", int'(rx_sh), int'(exp_bytes.pop_front()));
                    end
                    rx_active = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Busy pulse length monitor
    // ------------------------------------------------------------------
    initial begin : busy_monitor
        bit b_active;
        int b_start;
        b_active = 1'b0;
        b_start  = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                b_active = 1'b0;
            end else if (busy && !b_active) begin
                b_active = 1'b1;
                b_start  = cyc;
            end else if (!busy && b_active) begin
                b_active = 1'b0;
                if (exp_busy.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL busy_len: got %0d cycles expected no busy pulse", cyc - b_start);
                end else begin
                    check("busy_len", cyc - b_start, exp_busy.pop_front());
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy) begin
            if (n >= LIMIT) begin
                checks++;
                errors++;
                $display("FAIL wait_idle: got busy=1 expected busy=0 within %0d cycles", LIMIT);
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send(input logic [7:0] cmd, input logic [6:0] p1, input logic [6:0] p2,
                        input bit hold);
        int nb;
        wait_idle();
        bus.midi_command     = cmd;
        bus.midi_parameter_1 = p1;
        bus.midi_parameter_2 = p2;
        bus.midi_event_valid = 1'b1;
        nb = push_expect(cmd, p1, p2);
        @(posedge clk);
        #1;
        check("ack_pulse", int'(bus.midi_event_ack), 1);
        if (nb == 0) begin
            check("drop_busy", int'(busy), 0);
            check("drop_tx", int'(serial_tx), 1);
        end else begin
            check("first_start", int'(serial_tx), 0);
            check("busy_n1", int'(busy), 1);
        end
        if (!hold) begin
            @(negedge clk);
            bus.midi_event_valid = 1'b0;
            bus.midi_command     = 8'h55;   // later input changes are ignored
            bus.midi_parameter_1 = 7'h55;
            bus.midi_parameter_2 = 7'h55;
            @(posedge clk);
            #1;
            check("ack_single", int'(bus.midi_event_ack), 0);
        end
    endtask

    initial begin : stimulus
        int n;
        int early;
        int nb;
        bus.midi_command     = 8'h00;
        bus.midi_parameter_1 = 7'h00;
        bus.midi_parameter_2 = 7'h00;
        bus.midi_event_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", int'(serial_tx), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_ack", int'(bus.midi_event_ack), 0);
        @(negedge clk);
        resetn = 1'b1;

        // Note-on, 3 bytes
        send(8'h90, 7'h3C, 7'h64, 1'b0);
        // Program change, p2 never sent
        send(8'hC5, 7'h0A, 7'h7F, 1'b0);
        // Dropped events
        send(8'h3C, 7'h11, 7'h22, 1'b0);
        send(8'hF8, 7'h11, 7'h22, 1'b0);

        // Back-to-back with valid held across the first acknowledge
        send(8'h90, 7'h3C, 7'h64, 1'b1);
        @(negedge clk);
        bus.midi_command     = 8'h80;
        bus.midi_parameter_1 = 7'h3C;
        bus.midi_parameter_2 = 7'h00;
        nb = push_expect(8'h80, 7'h3C, 7'h00);
        n     = 0;
        early = 0;
        do begin
            @(negedge clk);
            if (bus.midi_event_ack) early++;
            n++;
        end while (busy && n < LIMIT);
        check("b2b_idle_reached", int'(busy), 0);
        check("b2b_no_early_ack", early, 0);
        @(posedge clk);
        #1;
        check("b2b_ack", int'(bus.midi_event_ack), 1);
        check("b2b_gap", int'(serial_tx), 0);
        @(negedge clk);
        bus.midi_event_valid = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_ack_single", int'(bus.midi_event_ack), 0);

        // Reset during the second byte of a note-on
        send(8'h90, 7'h3C, 7'h64, 1'b0);
        repeat (12 * DIV) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_tx", int'(serial_tx), 1);
        check("midrst_busy", int'(busy), 0);
        exp_bytes.delete();
        exp_busy.delete();
        model_status = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        send(8'h90, 7'h3C, 7'h64, 1'b0);

        // Running status sequence
        send(8'hC5, 7'h0A, 7'h7F, 1'b0);
        send(8'h90, 7'h3C, 7'h64, 1'b0);
        send(8'h90, 7'h3C, 7'h64, 1'b0);
        send(8'hF8, 7'h00, 7'h00, 1'b0);
        send(8'h90, 7'h3C, 7'h64, 1'b0);

        // Drain and confirm everything expected was observed
        wait_idle();
        repeat (12 * DIV) @(negedge clk);
        check("bytes_left", exp_bytes.size(), 0);
        check("busy_left", exp_busy.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
